// File: rtl/alu_sched_pkg.sv
// Shared opcode constants, FSM state type and opcode-class helpers for the ALU op scheduler.
// Purely declarative: no latency, no backpressure.
// Imported by alu_lat_decode and alu_op_scheduler.
package alu_sched_pkg;

    localparam logic [4:0] MUL    = 5'b00010;
    localparam logic [4:0] MULH   = 5'b00011;
    localparam logic [4:0] MULHSU = 5'b00100;
    localparam logic [4:0] MULHU  = 5'b00101;
    localparam logic [4:0] DIV    = 5'b00110;
    localparam logic [4:0] DIVU   = 5'b00111;
    localparam logic [4:0] REM    = 5'b01000;
    localparam logic [4:0] REMU   = 5'b01001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic is_mul(input logic [4:0] opc);
        return (opc >= MUL) && (opc <= MULHU);
    endfunction

    function automatic logic is_div(input logic [4:0] opc);
        return (opc >= DIV) && (opc <= REMU);
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/alu_lat_decode.sv
// Opcode to (LAT-1) decode: multiply class, divide class, everything else is a simple op.
// Latency: purely combinational.
// Backpressure: none; also consumed by the hazard unit for stall prediction.
module alu_lat_decode
    import alu_sched_pkg::*;
#(
    parameter int OPC_W    = 5,
    parameter int BASE_LAT = 2,
    parameter int MUL_LAT  = 4,
    parameter int DIV_LAT  = 34,
    parameter int CNT_W    = 6
) (
    input  logic [OPC_W-1:0] opcode,
    output logic [CNT_W-1:0] lat_m1
);

    logic [4:0] opc_lo;
    logic       hi_zero;

    always_comb begin
        opc_lo  = opcode[4:0];
        // opcodes wider than the 5-bit ISA field only match a class when the extra bits are clear
        hi_zero = ((opcode >> 5) == '0);
        lat_m1  = CNT_W'(BASE_LAT - 1);
        if (hi_zero && is_mul(opc_lo)) begin
            lat_m1 = CNT_W'(MUL_LAT - 1);
        end else if (hi_zero && is_div(opc_lo)) begin
            lat_m1 = CNT_W'(DIV_LAT - 1);
        end
    end

endmodule

// File: rtl/alu_op_scheduler.sv
// Sequencer in front of the multi-cycle ALU: holds operands for a class-dependent latency, returns answer + tag.
// Latency: rsp_valid rises LAT+1 clocks after the accepting edge (LAT = BASE/MUL/DIV_LAT by opcode class).
// Backpressure: req_ready only in IDLE; response held until rsp_ready. Optional macro ALU_DIV0_BYPASS_EN.
module alu_op_scheduler
    import alu_sched_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int OPC_W    = 5,
    parameter int TAG_W    = 5,
    parameter int BASE_LAT = 2,
    parameter int MUL_LAT  = 4,
    parameter int DIV_LAT  = 34
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_op1,
    input  logic [DATA_W-1:0] req_op2,
    input  logic [OPC_W-1:0]  req_opcode,
    input  logic [TAG_W-1:0]  req_tag,
    output logic [DATA_W-1:0] alu_operator_1,
    output logic [DATA_W-1:0] alu_operator_2,
    output logic [OPC_W-1:0]  alu_opcode,
    input  logic [DATA_W-1:0] alu_answer,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic              busy
);

    localparam int MAX_LAT = max3(BASE_LAT, MUL_LAT, DIV_LAT);
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    if (BASE_LAT < 1 || MUL_LAT < 1 || DIV_LAT < 1) begin : g_bad_lat
        $fatal(1, "alu_op_scheduler: latency parameters must be at least 1");
    end
    if (OPC_W < 5) begin : g_bad_opc
        $fatal(1, "alu_op_scheduler: OPC_W must cover the 5-bit opcode field");
    end

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   lat_m1;
    logic [CNT_W-1:0]   cnt_load;
    logic               first_q;
    logic [TAG_W-1:0]   tag_q;
    logic [DATA_W-1:0]  cap_dat;
    logic               accept;
    logic               cnt_done;

    alu_lat_decode #(
        .OPC_W    (OPC_W),
        .BASE_LAT (BASE_LAT),
        .MUL_LAT  (MUL_LAT),
        .DIV_LAT  (DIV_LAT),
        .CNT_W    (CNT_W)
    ) u_lat_decode (
        .opcode (req_opcode),
        .lat_m1 (lat_m1)
    );

    assign accept = req_valid && req_ready;
    // the first WAIT cycle covers the hop from our operand registers into the ALU input stage
    assign cnt_done = (state == WAIT) && !first_q && (cnt == '0);

`ifdef ALU_DIV0_BYPASS_EN
    logic              div0;
    logic              byp_q;
    logic [DATA_W-1:0] byp_dat;

    assign div0 = is_div(req_opcode[4:0]) && ((req_opcode >> 5) == '0) && (req_op2 == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            byp_q   <= 1'b0;
            byp_dat <= '0;
        end else if (accept) begin
            byp_q   <= div0;
            byp_dat <= ((req_opcode[4:0] == DIV) || (req_opcode[4:0] == DIVU)) ? '1 : req_op1;
        end
    end

    always_comb begin
        cnt_load = div0 ? '0 : lat_m1;
        cap_dat  = byp_q ? byp_dat : alu_answer;
    end
`else
    always_comb begin
        cnt_load = lat_m1;
        cap_dat  = alu_answer;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE:    if (accept)    state_nxt = WAIT;
                WAIT:    if (cnt_done)  state_nxt = RESP;
                RESP:    if (rsp_ready) state_nxt = IDLE;
                default:                state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        req_ready = (state == IDLE) && !flush;
        rsp_valid = (state == RESP);
        busy      = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_operator_1 <= '0;
            alu_operator_2 <= '0;
            alu_opcode     <= '0;
            tag_q          <= '0;
            cnt            <= '0;
            first_q        <= 1'b0;
            rsp_data       <= '0;
            rsp_tag        <= '0;
        end else if (flush) begin
            // alu_* deliberately keep their last values; only the sequencing is aborted
            cnt     <= '0;
            first_q <= 1'b0;
        end else if (accept) begin
            alu_operator_1 <= req_op1;
            alu_operator_2 <= req_op2;
            alu_opcode     <= req_opcode;
            tag_q          <= req_tag;
            cnt            <= cnt_load;
            first_q        <= 1'b1;
        end else if (state == WAIT) begin
            if (first_q) begin
                first_q <= 1'b0;
            end else if (cnt == '0) begin
                rsp_data <= cap_dat;
                rsp_tag  <= tag_q;
            end else begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Self-checking bench for alu_op_scheduler: directed vector table, hand-written corner sequences,
// then randomized ops scored against a rule-level reference model.
module tb_alu_op_scheduler;
    import alu_sched_pkg::*;

    localparam int DATA_W = 32, OPC_W = 5, TAG_W = 5;
    localparam int BASE_LAT = 2, MUL_LAT = 4, DIV_LAT = 34;
`ifdef ALU_DIV0_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst, flush, req_valid, req_ready, rsp_valid, rsp_ready, busy;
    logic [DATA_W-1:0] req_op1, req_op2, alu_operator_1, alu_operator_2, alu_answer, rsp_data;
    logic [OPC_W-1:0]  req_opcode, alu_opcode;
    logic [TAG_W-1:0]  req_tag, rsp_tag;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_op_scheduler #(
        .DATA_W(DATA_W), .OPC_W(OPC_W), .TAG_W(TAG_W),
        .BASE_LAT(BASE_LAT), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op1(req_op1), .req_op2(req_op2), .req_opcode(req_opcode), .req_tag(req_tag),
        .alu_operator_1(alu_operator_1), .alu_operator_2(alu_operator_2), .alu_opcode(alu_opcode),
        .alu_answer(alu_answer),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
        .busy(busy)
    );

    // stand-in ALU: answer available immediately, so any result error is the scheduler's
    function automatic logic [31:0] alu_fn(input logic [4:0] opc, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = 64'(a) * 64'(b);
        case (opc)
            5'd0:              return a + b;
            5'd1:              return a - b;
            5'd2:              return p[31:0];
            5'd3, 5'd4, 5'd5:  return p[63:32];
            5'd6:              return (b == 0) ? (32'hBAD0_0000 ^ a) : 32'($signed(a) / $signed(b));
            5'd7:              return (b == 0) ? (32'hBAD0_0000 ^ a) : a / b;
            5'd8:              return (b == 0) ? (32'hBAD0_0000 ^ a) : 32'($signed(a) % $signed(b));
            5'd9:              return (b == 0) ? (32'hBAD0_0000 ^ a) : a % b;
            default:           return a ^ b ^ 32'(opc);
        endcase
    endfunction

    always_comb alu_answer = alu_fn(alu_opcode, alu_operator_1, alu_operator_2);

    function automatic int ref_lat(input logic [4:0] opc, input logic [31:0] b);
        if (opc >= 5'd2 && opc <= 5'd5) return MUL_LAT;
        if (opc >= 5'd6 && opc <= 5'd9) return (BYP && b == 0) ? 1 : DIV_LAT;
        return BASE_LAT;
    endfunction

    function automatic logic [31:0] ref_rsp(input logic [4:0] opc, input logic [31:0] a, input logic [31:0] b);
        if (BYP && b == 0 && opc >= 5'd6 && opc <= 5'd9) return (opc <= 5'd7) ? 32'hFFFF_FFFF : a;
        return alu_fn(opc, a, b);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble_req();
        req_op1    = $urandom;
        req_op2    = $urandom;
        req_opcode = 5'($urandom);
        req_tag    = 5'($urandom);
    endtask

    // counts edges until rsp_valid; flags req_ready or operand movement seen meanwhile
    task automatic wait_rsp(input logic [4:0] opc, input logic [31:0] a, input logic [31:0] b,
                            output int n, output bit bad);
        n   = 0;
        bad = 1'b0;
        while (!rsp_valid && n < 100) begin
            if (req_ready || alu_opcode !== opc || alu_operator_1 !== a || alu_operator_2 !== b) bad = 1'b1;
            step();
            n++;
        end
    endtask

    task automatic run_op(input string name, input logic [4:0] opc, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] tag, input int hold,
                          input logic [31:0] exp_dat, input int exp_lat);
        int n;
        bit bad;
        logic [31:0] d0;
        logic [4:0]  t0;
        req_opcode = opc; req_op1 = a; req_op2 = b; req_tag = tag; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 100) begin step(); n++; end
        step();
        req_valid = 1'b0;
        scramble_req();
        rsp_ready = (hold == 0);
        wait_rsp(opc, a, b, n, bad);
        check({name, "_lat"}, 64'(n), 64'(exp_lat + 1));
        check({name, "_data"}, 64'(rsp_data), 64'(exp_dat));
        check({name, "_tag"}, 64'(rsp_tag), 64'(tag));
        d0 = rsp_data;
        t0 = rsp_tag;
        for (int i = 0; i < hold; i++) begin
            step();
            if (!rsp_valid || req_ready || rsp_data !== d0 || rsp_tag !== t0) bad = 1'b1;
        end
        check({name, "_hold"}, 64'(bad), 64'd0);
        rsp_ready = 1'b1;
        step();
        check({name, "_done"}, {62'd0, rsp_valid, busy}, 64'd0);
    endtask

    typedef struct {
        logic [4:0]  opc;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  tag;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int n;
        bit bad;
        logic [4:0]  ro;
        logic [31:0] ra, rb;

        vecs[0]  = '{5'b00000, 32'd5,         32'd7,       5'd3,  32'd12,        BASE_LAT};
        vecs[1]  = '{5'b00010, 32'd6,         32'd7,       5'd9,  32'd42,        MUL_LAT};
        vecs[2]  = '{5'b00111, 32'd100,       32'd7,       5'd10, 32'd14,        DIV_LAT};
        vecs[3]  = '{5'b01001, 32'd100,       32'd7,       5'd11, 32'd2,         DIV_LAT};
        vecs[4]  = '{5'b00110, 32'hFFFF_FFEC, 32'd3,       5'd12, 32'hFFFF_FFFA, DIV_LAT};
        vecs[5]  = '{5'b01000, 32'hFFFF_FFEC, 32'd3,       5'd13, 32'hFFFF_FFFE, DIV_LAT};
        vecs[6]  = '{5'b00101, 32'h0001_0000, 32'h1_0000,  5'd14, 32'd1,         MUL_LAT};
        vecs[7]  = '{5'b00001, 32'd10,        32'd3,       5'd15, 32'd7,         BASE_LAT};
        vecs[8]  = '{5'b01010, 32'hF0,        32'h0F,      5'd16, 32'hF5,        BASE_LAT};
        vecs[9]  = '{5'b00110, 32'd123,       32'd0,       5'd20,
                     BYP ? 32'hFFFF_FFFF : 32'hBAD0_007B, BYP ? 1 : DIV_LAT};
        vecs[10] = '{5'b01000, 32'd123,       32'd0,       5'd21,
                     BYP ? 32'd123 : 32'hBAD0_007B,       BYP ? 1 : DIV_LAT};
        vecs[11] = '{5'b11111, 32'd1,         32'd2,       5'd31, 32'h1C,        BASE_LAT};

        rst = 1'b1; flush = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
        req_op1 = '0; req_op2 = '0; req_opcode = '0; req_tag = '0;
        step(); step();
        check("reset_alu_ops", {alu_operator_1, alu_operator_2}, 64'd0);
        check("reset_flags", {59'd0, alu_opcode == 5'd0, rsp_valid, busy, rsp_data == 32'd0, rsp_tag == 5'd0},
              {59'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1});
        rst = 1'b0;
        #1;
        check("ready_after_reset", 64'(req_ready), 64'd1);

        for (int i = 0; i < 12; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].opc, vecs[i].a, vecs[i].b, vecs[i].tag,
                   i % 3, vecs[i].exp, vecs[i].lat);
        end

        // backpressure for 10 cycles, next request held valid the whole time
        rsp_ready = 1'b0;
        req_opcode = 5'd0; req_op1 = 32'd10; req_op2 = 32'd20; req_tag = 5'd4; req_valid = 1'b1;
        step();
        req_opcode = MUL; req_op1 = 32'd3; req_op2 = 32'd4; req_tag = 5'd5;
        wait_rsp(5'd0, 32'd10, 32'd20, n, bad);
        check("bp_lat", 64'(n), 64'(BASE_LAT + 1));
        for (int i = 0; i < 10; i++) begin
            step();
            if (!rsp_valid || req_ready || rsp_data !== 32'd30 || rsp_tag !== 5'd4) bad = 1'b1;
        end
        check("bp_stable", 64'(bad), 64'd0);
        rsp_ready = 1'b1;
        step();
        check("bp_after_hs", {61'd0, req_ready, busy, rsp_valid}, {61'd0, 1'b1, 1'b0, 1'b0});
        step();
        check("bp_next_accept", {62'd0, busy, req_ready}, {62'd0, 1'b1, 1'b0});
        req_valid = 1'b0;
        wait_rsp(MUL, 32'd3, 32'd4, n, bad);
        check("bp_next_lat", 64'(n), 64'(MUL_LAT + 1));
        check("bp_next_data", {27'd0, rsp_tag, rsp_data}, {27'd0, 5'd5, 32'd12});
        step();

        // flush in the 10th WAIT cycle of a divide
        req_opcode = DIV; req_op1 = 32'd1000; req_op2 = 32'd10; req_tag = 5'd22; req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        for (int i = 0; i < 9; i++) step();
        flush = 1'b1;
        req_opcode = 5'd0; req_op1 = 32'd1; req_op2 = 32'd1; req_tag = 5'd1; req_valid = 1'b1;
        #1;
        check("flush_blocks_ready", 64'(req_ready), 64'd0);
        step();
        flush = 1'b0; req_valid = 1'b0;
        check("flush_idle", {62'd0, busy, rsp_valid}, 64'd0);
        check("flush_alu_kept", {27'd0, alu_opcode, alu_operator_1}, {27'd0, DIV, 32'd1000});
        bad = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (rsp_valid) bad = 1'b1;
            step();
        end
        check("flush_no_rsp", 64'(bad), 64'd0);
        run_op("post_flush_add", 5'd0, 32'd40, 32'd2, 5'd7, 0, 32'd42, BASE_LAT);

        // synchronous reset mid-divide returns every output to its reset value
        req_opcode = DIVU; req_op1 = 32'd50; req_op2 = 32'd5; req_tag = 5'd8; req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("rst_mid_alu", {alu_operator_1, alu_operator_2}, 64'd0);
        check("rst_mid_out", {27'd0, alu_opcode, rsp_data}, 64'd0);
        check("rst_mid_flags", {56'd0, rsp_tag, rsp_valid, busy, req_ready}, {56'd0, 5'd0, 1'b0, 1'b0, 1'b1});
        bad = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (rsp_valid) bad = 1'b1;
            step();
        end
        check("rst_no_rsp", 64'(bad), 64'd0);

        for (int i = 0; i < 30; i++) begin
            ro = ($urandom_range(0, 5) == 0) ? 5'($urandom) : 5'($urandom_range(0, 11));
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 1000));
            run_op($sformatf("rand%0d", i), ro, ra, rb, 5'($urandom), $urandom_range(0, 3),
                   ref_rsp(ro, ra, rb), ref_lat(ro, rb));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_op_scheduler.md
Name: alu_op_scheduler

Overview:
Sequencer in front of the multi-cycle ALU. It accepts one operation at a time from the execute stage using a valid/ready handshake. It drives and holds the ALU operands and opcode for a class-dependent latency: logic/add/shift, multiply, or divide. It then captures the ALU answer and returns it with its destination tag through a valid/ready response handshake. The execute stage stalls on req_ready low.

Parameters:
DATA_W, 32, operand/result width
OPC_W, 5, ALU opcode width
TAG_W, 5, destination register tag width
BASE_LAT, 2, cycles from ALU input change to valid answer for simple ops (input register plus output register)
MUL_LAT, 4, cycles for opcodes 00010-00101
DIV_LAT, 34, cycles for opcodes 00110-01001

Ports:
clk  in  1  system clock; the same clock drives the ALU clk_alu
rst  in  1  synchronous active-high reset
flush  in  1  abort the in-flight operation and drop any pending response
req_valid  in  1  request present
req_ready  out  1  scheduler can accept a request
req_op1  in  DATA_W  operand 1
req_op2  in  DATA_W  operand 2
req_opcode  in  OPC_W  ALU opcode
req_tag  in  TAG_W  destination tag
alu_operator_1  out  DATA_W  to ALU operator_1
alu_operator_2  out  DATA_W  to ALU operator_2
alu_opcode  out  OPC_W  to ALU opcode
alu_answer  in  DATA_W  from ALU answer
rsp_valid  out  1  result present
rsp_ready  in  1  consumer accepts the result
rsp_data  out  DATA_W  captured result
rsp_tag  out  TAG_W  tag of the result
busy  out  1  state is not IDLE

Behaviour:
- One clock (clk) with synchronous, active-high reset (rst). All state changes on the posedge of clk.
- Reset state:
  - State is IDLE.
  - alu_* outputs are 0; opcode 0 is add, which is harmless.
  - rsp_valid=0, rsp_data=0, rsp_tag=0, busy=0, counter=0.
  - req_ready=1 from the first cycle after reset deasserts.
- States and transitions:
  - IDLE to WAIT on accept.
  - WAIT to RESP when the counter reaches 0.
  - RESP to IDLE on rsp_valid && rsp_ready.
- req_ready = (state==IDLE) && !flush. The output is combinational from state; there is no path from req_valid to req_ready.
- Accept = req_valid && req_ready. On the accepting edge:
  - alu_operator_1/2 and alu_opcode register the request fields and hold them unchanged until the next accept.
  - The tag is latched.
  - The counter loads LAT-1, where LAT = MUL_LAT for opcodes 00010-00101, DIV_LAT for opcodes 00110-01001, and BASE_LAT for all other opcodes.
- WAIT: the counter decrements each cycle. In the cycle where the counter is 0:
  - rsp_data <= alu_answer and rsp_tag <= tag.
  - rsp_valid <= 1 and the state moves to RESP.
- Latency: rsp_valid rises exactly LAT+1 clocks after the accepting edge.
- RESP: rsp_data and rsp_tag are held stable while rsp_valid=1 && !rsp_ready. There is no accept in the handshake cycle; the next accept is possible one cycle later.
- Flush has priority over every other event in every state:
  - The next state is IDLE and rsp_valid is cleared.
  - The counter clears and no response is ever issued for the aborted operation.
  - alu_* outputs keep their last values.
- Flush in the same cycle as req_valid: the request is not accepted, because req_ready is low.
- Reset mid-operation is identical to flush, and in addition all outputs return to their reset values.
- Counter width is clog2(max(BASE_LAT, MUL_LAT, DIV_LAT)). A parameter value below 1 is illegal; the block asserts at elaboration.

Optional Feature:
ALU_DIV0_BYPASS_EN:
- Defined: a divide-class request with req_op2==0 does not wait DIV_LAT. It uses LAT=1, and the result is synthesized instead of taken from alu_answer:
  - DIV/DIVU (00110/00111) return 32'hFFFF_FFFF.
  - REM/REMU (01000/01001) return req_op1.
- Undefined: divide by zero waits DIV_LAT and returns alu_answer unmodified.

Decomposition:
- Package alu_sched_pkg holds:
  - Opcode localparams MUL=00010, MULH=00011, MULHSU=00100, MULHU=00101, DIV=00110, DIVU=00111, REM=01000, REMU=01001.
  - The state enum {IDLE, WAIT, RESP}.
  - The functions is_mul(opc) and is_div(opc).
- One sub-module: alu_lat_decode, combinational opcode to LAT-1 decode. It is reused by the hazard unit for stall prediction.

Test Plan:
1. Add (opc 00000), op1=5, op2=7, tag=3, rsp_ready=1 -> rsp_valid exactly 3 clocks after accept; rsp_data=12, rsp_tag=3; req_ready low for those cycles.
2. MUL (00010), 6*7, tag=9 -> rsp_valid 5 clocks after accept, data=42; alu_opcode/operands stable throughout WAIT.
3. DIVU (00111), 100/7 -> rsp at 35 clocks, data=14. Then REMU with the same operands -> data=2.
4. Backpressure: rsp_ready=0 for 10 cycles after rsp_valid -> data/tag stable and req_ready stays 0. Raise rsp_ready with req_valid held -> next accept exactly one cycle after the handshake.
5. Flush in the 10th WAIT cycle of a DIV -> IDLE next cycle, no rsp_valid ever for that tag, a following add completes normally. Repeat with rst instead of flush -> all outputs 0.
6. With ALU_DIV0_BYPASS_EN, DIV 123/0 -> rsp at 2 clocks, data=FFFF_FFFF; REM 123/0 -> data=123. Without the macro, the response arrives at 35 clocks.
